// File: rtl/fake_n64_link_sequencer.sv
// Arbitrates the shared N64 data line between the RX and TX engines: filter command, wait idle + turnaround, run TX with timeout, guard, re-arm RX.
// All outputs registered; optional statistics counters enabled by FAKE_N64_SEQ_STATS_EN.
module fake_n64_link_sequencer #(
    parameter int IDLE_CYCLES  = 4,
    parameter int TURN_CYCLES  = 8,
    parameter int TX_TIMEOUT   = 2048,
    parameter int GUARD_CYCLES = 4,
    parameter int CNT_W        = 12
) (
    input  logic       sample_clk,
    input  logic       reset,
    input  logic       data_rx,
    input  logic       rx_cmd_valid,
    input  logic [7:0] rx_cmd,
    input  logic       tx_done,
    output logic       rx_enable,
    output logic       cur_operation,
    output logic       tx_start,
    output logic [7:0] tx_cmd,
    output logic       tx_abort,
    output logic       busy,
    output logic       err_overrun,
    output logic       err_timeout
`ifdef FAKE_N64_SEQ_STATS_EN
    ,
    output logic [15:0] stat_cmds,
    output logic [7:0]  stat_drops,
    output logic [7:0]  stat_aborts
`endif
);

    typedef enum logic [2:0] {
        IDLE_RX,
        DROP,
        WAIT_IDLE,
        TURNAROUND,
        TX_ACTIVE,
        GUARD
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             rx_enable_q, rx_enable_d;
    logic             cur_op_q, cur_op_d;
    logic             tx_start_q, tx_start_d;
    logic             tx_abort_q, tx_abort_d;
    logic [7:0]       tx_cmd_q, tx_cmd_d;
    logic             err_overrun_q, err_overrun_d;
    logic             err_timeout_q, err_timeout_d;
    logic             cmd_ok;
    logic             ev_drop;

    always_comb begin
        cmd_ok = (rx_cmd == 8'h00) || (rx_cmd == 8'h01) || (rx_cmd == 8'h02) ||
                 (rx_cmd == 8'h03) || (rx_cmd == 8'hFF);
    end

    always_comb begin
        state_d       = state_q;
        cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_d         = cnt_q;
        rx_enable_d   = rx_enable_q;
        cur_op_d      = cur_op_q;
        tx_start_d    = 1'b0;
        tx_abort_d    = 1'b0;
        tx_cmd_d      = tx_cmd_q;
        err_timeout_d = err_timeout_q;
        err_overrun_d = err_overrun_q | (rx_cmd_valid && (state_q != IDLE_RX));
        ev_drop       = 1'b0;

        case (state_q)
            IDLE_RX: begin
                if (rx_cmd_valid) begin
                    rx_enable_d = 1'b0;
                    cnt_d       = '0;
                    if (cmd_ok) begin
                        tx_cmd_d = rx_cmd;
                        state_d  = WAIT_IDLE;
                    end else begin
                        ev_drop = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            // Both states need IDLE_CYCLES consecutive high samples; a low sample restarts.
            DROP, WAIT_IDLE: begin
                if (!data_rx) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    cnt_d = '0;
                    if (state_q == DROP) begin
                        state_d     = IDLE_RX;
                        rx_enable_d = 1'b1;
                    end else begin
                        state_d  = TURNAROUND;
                        cur_op_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TURNAROUND: begin
                if (cnt_q == TURN_LAST) begin
                    state_d    = TX_ACTIVE;
                    cnt_d      = '0;
                    tx_start_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TX_ACTIVE: begin
                if (tx_done) begin
                    state_d  = GUARD;
                    cnt_d    = '0;
                    cur_op_d = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d       = GUARD;
                    cnt_d         = '0;
                    cur_op_d      = 1'b0;
                    tx_abort_d    = 1'b1;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d     = IDLE_RX;
                    cnt_d       = '0;
                    rx_enable_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d     = IDLE_RX;
                cnt_d       = '0;
                rx_enable_d = 1'b1;
                cur_op_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state_q       <= IDLE_RX;
            cnt_q         <= '0;
            rx_enable_q   <= 1'b1;
            cur_op_q      <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_abort_q    <= 1'b0;
            tx_cmd_q      <= 8'h00;
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rx_enable_q   <= rx_enable_d;
            cur_op_q      <= cur_op_d;
            tx_start_q    <= tx_start_d;
            tx_abort_q    <= tx_abort_d;
            tx_cmd_q      <= tx_cmd_d;
            err_overrun_q <= err_overrun_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign rx_enable     = rx_enable_q;
    assign cur_operation = cur_op_q;
    assign tx_start      = tx_start_q;
    assign tx_abort      = tx_abort_q;
    assign tx_cmd        = tx_cmd_q;
    assign busy          = (state_q != IDLE_RX);
    assign err_overrun   = err_overrun_q;
    assign err_timeout   = err_timeout_q;

`ifdef FAKE_N64_SEQ_STATS_EN
    logic [15:0] stat_cmds_q, stat_cmds_d;
    logic [7:0]  stat_drops_q, stat_drops_d;
    logic [7:0]  stat_aborts_q, stat_aborts_d;

    always_comb begin
        stat_cmds_d   = stat_cmds_q;
        stat_drops_d  = stat_drops_q;
        stat_aborts_d = stat_aborts_q;
        if (tx_start_d && (stat_cmds_q != 16'hFFFF)) stat_cmds_d = stat_cmds_q + 16'd1;
        if (ev_drop && (stat_drops_q != 8'hFF)) stat_drops_d = stat_drops_q + 8'd1;
        if (tx_abort_d && (stat_aborts_q != 8'hFF)) stat_aborts_d = stat_aborts_q + 8'd1;
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            stat_cmds_q   <= '0;
            stat_drops_q  <= '0;
            stat_aborts_q <= '0;
        end else begin
            stat_cmds_q   <= stat_cmds_d;
            stat_drops_q  <= stat_drops_d;
            stat_aborts_q <= stat_aborts_d;
        end
    end

    assign stat_cmds   = stat_cmds_q;
    assign stat_drops  = stat_drops_q;
    assign stat_aborts = stat_aborts_q;
`endif

endmodule

// File: tb/tb_fake_n64_link_sequencer.sv
// Directed bench for fake_n64_link_sequencer; tx_start events are matched against a scoreboard of expected (cmd, cycle) entries.
module tb_fake_n64_link_sequencer;

    logic       sample_clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_rx = 1'b1;
    logic       rx_cmd_valid = 1'b0;
    logic [7:0] rx_cmd = 8'h00;
    logic       tx_done = 1'b0;
    logic       rx_enable, cur_operation, tx_start, tx_abort, busy, err_overrun, err_timeout;
    logic [7:0] tx_cmd;
`ifdef FAKE_N64_SEQ_STATS_EN
    logic [15:0] stat_cmds;
    logic [7:0]  stat_drops, stat_aborts;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] cmd;
        int         at;
    } exp_t;
    exp_t sb_q[$];

    fake_n64_link_sequencer dut (
        .sample_clk    (sample_clk),
        .reset         (reset),
        .data_rx       (data_rx),
        .rx_cmd_valid  (rx_cmd_valid),
        .rx_cmd        (rx_cmd),
        .tx_done       (tx_done),
        .rx_enable     (rx_enable),
        .cur_operation (cur_operation),
        .tx_start      (tx_start),
        .tx_cmd        (tx_cmd),
        .tx_abort      (tx_abort),
        .busy          (busy),
        .err_overrun   (err_overrun),
        .err_timeout   (err_timeout)
`ifdef FAKE_N64_SEQ_STATS_EN
        ,
        .stat_cmds     (stat_cmds),
        .stat_drops    (stat_drops),
        .stat_aborts   (stat_aborts)
`endif
    );

    always #5 sample_clk = ~sample_clk;
    always @(posedge sample_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sample_clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step(1);
    endtask

    // Drives a one-cycle command pulse; t0 is the cycle the pulse is presented in.
    task automatic send(input logic [7:0] c, output int t0);
        rx_cmd       = c;
        rx_cmd_valid = 1'b1;
        t0           = cyc;
        step(1);
        rx_cmd_valid = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_enable"}, rx_enable, 1);
        check({tag, "_cur_op"}, cur_operation, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_cmd"}, tx_cmd, 0);
        check({tag, "_tx_abort"}, tx_abort, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err_overrun"}, err_overrun, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
`ifdef FAKE_N64_SEQ_STATS_EN
        check({tag, "_stat_cmds"}, stat_cmds, 0);
        check({tag, "_stat_drops"}, stat_drops, 0);
        check({tag, "_stat_aborts"}, stat_aborts, 0);
`endif
    endtask

    // Every tx_start must match the oldest expected entry in command and cycle.
    always @(negedge sample_clk) begin
        if (!reset && tx_start) begin
            if (sb_q.size() == 0) begin
                check("tx_start_unexpected", tx_start, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("tx_start_cycle", cyc, e.at);
                check("tx_start_cmd", tx_cmd, e.cmd);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int td;

        // Reset values
        step(3);
        check_reset_vals("reset");
        reset = 1'b0;
        step(2);

        // Case 1: supported cmd, line idle, normal completion
        send(8'h01, t0);
        sb_q.push_back('{cmd: 8'h01, at: t0 + 13});
        check("c1_rx_enable_drop", rx_enable, 0);
        check("c1_busy", busy, 1);
        check("c1_cur_op_wait", cur_operation, 0);
        wait_to(t0 + 5);
        check("c1_cur_op_turn", cur_operation, 1);
        wait_to(t0 + 12);
        check("c1_no_early_start", tx_start, 0);
        wait_to(t0 + 13);
        check("c1_tx_start", tx_start, 1);
        td = cyc;
        pulse_done();
        check("c1_cur_op_guard", cur_operation, 0);
        check("c1_tx_start_pulse", tx_start, 0);
        wait_to(td + 4);
        check("c1_guard_rx_enable", rx_enable, 0);
        wait_to(td + 5);
        check("c1_rx_enable_back", rx_enable, 1);
        check("c1_idle_busy", busy, 0);
        step(2);

        // Case 2: unsupported cmd is dropped
        send(8'h5A, t0);
        check("c2_busy", busy, 1);
        check("c2_rx_enable_drop", rx_enable, 0);
        wait_to(t0 + 3);
        check("c2_cur_op", cur_operation, 0);
        wait_to(t0 + 4);
        check("c2_still_drop", busy, 1);
        wait_to(t0 + 5);
        check("c2_idle", busy, 0);
        check("c2_rx_enable_back", rx_enable, 1);
        step(2);

        // Case 3: line glitch on third idle sample delays tx_start by 3
        send(8'h00, t0);
        sb_q.push_back('{cmd: 8'h00, at: t0 + 16});
        wait_to(t0 + 3);
        data_rx = 1'b0;
        step(1);
        data_rx = 1'b1;
        wait_to(t0 + 7);
        check("c3_cur_op_still_rx", cur_operation, 0);
        wait_to(t0 + 8);
        check("c3_cur_op_turn", cur_operation, 1);
        wait_to(t0 + 16);
        check("c3_tx_start", tx_start, 1);
        td = cyc;
        pulse_done();
        wait_to(td + 5);
        check("c3_rx_enable_back", rx_enable, 1);
        step(2);

        // Case 4: timeout; TX_ACTIVE spans cycles t0+13..t0+2060, abort visible at t0+2061
        send(8'hFF, t0);
        sb_q.push_back('{cmd: 8'hFF, at: t0 + 13});
        wait_to(t0 + 2060);
        check("c4_no_early_abort", tx_abort, 0);
        check("c4_err_timeout_clear", err_timeout, 0);
        check("c4_cur_op_tx", cur_operation, 1);
        wait_to(t0 + 2061);
        check("c4_tx_abort", tx_abort, 1);
        check("c4_err_timeout", err_timeout, 1);
        check("c4_cur_op_guard", cur_operation, 0);
        wait_to(t0 + 2062);
        check("c4_abort_pulse", tx_abort, 0);
        wait_to(t0 + 2065);
        check("c4_rx_enable_back", rx_enable, 1);
        check("c4_idle", busy, 0);
        step(2);

        // Case 4b: tx_done on the timeout cycle wins
        send(8'h03, t0);
        sb_q.push_back('{cmd: 8'h03, at: t0 + 13});
        wait_to(t0 + 2060);
        pulse_done();
        check("c4b_no_abort", tx_abort, 0);
        check("c4b_cur_op_guard", cur_operation, 0);
        wait_to(t0 + 2065);
        check("c4b_rx_enable_back", rx_enable, 1);
        step(2);

        // Case 5: overrun during TURNAROUND, stray tx_done ignored
        send(8'h02, t0);
        sb_q.push_back('{cmd: 8'h02, at: t0 + 13});
        wait_to(t0 + 7);
        check("c5_overrun_before", err_overrun, 0);
        rx_cmd       = 8'h03;
        rx_cmd_valid = 1'b1;
        step(1);
        rx_cmd_valid = 1'b0;
        check("c5_err_overrun", err_overrun, 1);
        check("c5_cur_op", cur_operation, 1);
        wait_to(t0 + 9);
        pulse_done();
        wait_to(t0 + 13);
        check("c5_tx_start", tx_start, 1);
        check("c5_tx_cmd", tx_cmd, 8'h02);
        td = cyc;
        pulse_done();
        wait_to(td + 5);
        check("c5_rx_enable_back", rx_enable, 1);
        check("c5_overrun_sticky", err_overrun, 1);
        step(2);

        // Case 6: reset mid TX_ACTIVE
        send(8'h01, t0);
        sb_q.push_back('{cmd: 8'h01, at: t0 + 13});
        wait_to(t0 + 20);
        check("c6_busy", busy, 1);
        check("c6_cur_op", cur_operation, 1);
        check("c6_err_timeout", err_timeout, 1);
        check("c6_tx_cmd", tx_cmd, 8'h01);
`ifdef FAKE_N64_SEQ_STATS_EN
        check("c6_stat_cmds", stat_cmds, 6);
        check("c6_stat_drops", stat_drops, 1);
        check("c6_stat_aborts", stat_aborts, 1);
`endif
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_reset_vals("c6_reset");
        step(20);
        check("c6_no_resume", busy, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
